// File: rtl/lift_travel_timer.sv
// Floor-by-floor travel timer for the lift controller: tracks the live floor,
// pulses on every floor crossing and on arrival, and rejects illegal requests.
module lift_travel_timer #(
  parameter int STATE_W       = 32,
  parameter int FLOOR_W       = 5,
  parameter int NUM_FLOORS    = 16,
  parameter int CYC_PER_FLOOR = 4,
  parameter int CNT_W         = 16,
  parameter int ST_MOVE_UP    = 4,
  parameter int ST_MOVE_DOWN  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] current_state,
  input  logic [FLOOR_W-1:0] pfloor,
  input  logic [FLOOR_W-1:0] nfloor,
  input  logic               abort,
  output logic               busy,
  output logic [FLOOR_W-1:0] live_floor,
  output logic               floor_tick,
  output logic               reached,
  output logic               req_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [STATE_W-1:0] ST_UP     = STATE_W'(ST_MOVE_UP);
  localparam logic [STATE_W-1:0] ST_DN     = STATE_W'(ST_MOVE_DOWN);
  localparam logic [FLOOR_W:0]   NF_LIMIT  = (FLOOR_W+1)'(NUM_FLOORS);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CYC_PER_FLOOR - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [FLOOR_W-1:0] target;
  logic               dir_up;

  logic               move_up;
  logic               move_dn;
  logic               move;
  logic               bad_req;
  logic [FLOOR_W-1:0] next_floor;

  assign move_up = (current_state == ST_UP);
  assign move_dn = (current_state == ST_DN);
  assign move    = move_up || move_dn;

  // Out-of-range floors or a direction that contradicts the requested target.
  assign bad_req = ({1'b0, pfloor} >= NF_LIMIT) || ({1'b0, nfloor} >= NF_LIMIT) ||
                   (move_up && (nfloor < pfloor)) || (move_dn && (nfloor > pfloor));

  assign next_floor = dir_up ? (live_floor + 1'b1) : (live_floor - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      target     <= '0;
      dir_up     <= 1'b0;
      busy       <= 1'b0;
      live_floor <= '0;
      floor_tick <= 1'b0;
      reached    <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      floor_tick <= 1'b0;
      reached    <= 1'b0;
      req_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (move) begin
            if (bad_req) begin
              req_err <= 1'b1;
            end else if (nfloor == pfloor) begin
              reached    <= 1'b1;
              live_floor <= pfloor;
              state      <= DONE;
            end else begin
              target     <= nfloor;
              dir_up     <= move_up;
              live_floor <= pfloor;
              cnt        <= '0;
              busy       <= 1'b1;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          // Abort wins over a floor crossing that lands on the same edge.
          if (abort || !move) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt        <= '0;
            live_floor <= next_floor;
            floor_tick <= 1'b1;
            if (next_floor == target) begin
              reached <= 1'b1;
              busy    <= 1'b0;
              state   <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!move) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lift_travel_timer.sv
// Directed bench for lift_travel_timer: default timing instance plus a
// one-cycle-per-floor instance sharing the same stimulus.
module tb_lift_travel_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] current_state = '0;
  logic [4:0]  pfloor = '0;
  logic [4:0]  nfloor = '0;
  logic        abort = 1'b0;

  logic        busy, floor_tick, reached, req_err;
  logic [4:0]  live_floor;
  logic        busy2, floor_tick2, reached2, req_err2;
  logic [4:0]  live_floor2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lift_travel_timer dut (
    .clk(clk), .rst_n(rst_n), .current_state(current_state),
    .pfloor(pfloor), .nfloor(nfloor), .abort(abort),
    .busy(busy), .live_floor(live_floor), .floor_tick(floor_tick),
    .reached(reached), .req_err(req_err)
  );

  lift_travel_timer #(.CYC_PER_FLOOR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .current_state(current_state),
    .pfloor(pfloor), .nfloor(nfloor), .abort(abort),
    .busy(busy2), .live_floor(live_floor2), .floor_tick(floor_tick2),
    .reached(reached2), .req_err(req_err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({busy, live_floor, floor_tick, reached, req_err} !== 9'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs got %b want 0",
               {busy, live_floor, floor_tick, reached, req_err});
    end
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_up_travel();
    pfloor = 5'd2; nfloor = 5'd5; current_state = 32'd4;
    step();
    tests++;
    if (busy !== 1'b1 || live_floor !== 5'd2 || floor_tick !== 1'b0) begin
      fails++;
      $display("[TB] FAIL up_start busy=%b live=%0d tick=%b want 1 2 0", busy, live_floor, floor_tick);
    end
    for (int c = 1; c <= 12; c++) begin
      step();
      tests++;
      if (floor_tick !== (c % 4 == 0) || live_floor !== 5'(2 + c / 4) ||
          reached !== (c == 12) || busy !== (c < 12)) begin
        fails++;
        $display("[TB] FAIL up_cycle%0d tick=%b live=%0d reached=%b busy=%b want %b %0d %b %b",
                 c, floor_tick, live_floor, reached, busy, (c % 4 == 0), 2 + c / 4, (c == 12), (c < 12));
      end
    end
    step();
    tests++;
    if (reached !== 1'b0 || busy !== 1'b0 || floor_tick !== 1'b0) begin
      fails++;
      $display("[TB] FAIL up_after reached=%b busy=%b tick=%b want 0 0 0", reached, busy, floor_tick);
    end
    current_state = 32'd0;
    step();
  endtask

  task automatic test_down_travel();
    pfloor = 5'd9; nfloor = 5'd1; current_state = 32'd5;
    step();
    for (int c = 1; c <= 32; c++) begin
      step();
      tests++;
      if (floor_tick !== (c % 4 == 0) || live_floor !== 5'(9 - c / 4) ||
          reached !== (c == 32) || busy !== (c < 32)) begin
        fails++;
        $display("[TB] FAIL down_cycle%0d tick=%b live=%0d reached=%b busy=%b want %b %0d %b %b",
                 c, floor_tick, live_floor, reached, busy, (c % 4 == 0), 9 - c / 4, (c == 32), (c < 32));
      end
    end
    for (int c = 0; c < 6; c++) begin
      step();
      tests++;
      if (busy !== 1'b0 || floor_tick !== 1'b0 || reached !== 1'b0 || live_floor !== 5'd1) begin
        fails++;
        $display("[TB] FAIL down_noretrigger%0d busy=%b tick=%b reached=%b live=%0d want 0 0 0 1",
                 c, busy, floor_tick, reached, live_floor);
      end
    end
    current_state = 32'd0;
    step();
  endtask

  task automatic test_req_err();
    logic [4:0] pf [3] = '{5'd6, 5'd3, 5'd16};
    logic [4:0] nf [3] = '{5'd3, 5'd20, 5'd2};
    logic [31:0] st [3] = '{32'd4, 32'd4, 32'd5};
    for (int i = 0; i < 3; i++) begin
      pfloor = pf[i]; nfloor = nf[i]; current_state = st[i];
      step();
      tests++;
      if (req_err !== 1'b1 || busy !== 1'b0 || reached !== 1'b0) begin
        fails++;
        $display("[TB] FAIL err%0d_pulse req_err=%b busy=%b reached=%b want 1 0 0", i, req_err, busy, reached);
      end
      current_state = 32'd0;
      step();
      tests++;
      if (req_err !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL err%0d_clear req_err=%b busy=%b want 0 0", i, req_err, busy);
      end
    end
  endtask

  task automatic test_same_floor();
    pfloor = 5'd7; nfloor = 5'd7; current_state = 32'd4;
    step();
    tests++;
    if (reached !== 1'b1 || busy !== 1'b0 || floor_tick !== 1'b0 || live_floor !== 5'd7) begin
      fails++;
      $display("[TB] FAIL same_pulse reached=%b busy=%b tick=%b live=%0d want 1 0 0 7",
               reached, busy, floor_tick, live_floor);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (reached !== 1'b0 || busy !== 1'b0 || floor_tick !== 1'b0) begin
        fails++;
        $display("[TB] FAIL same_hold%0d reached=%b busy=%b tick=%b want 0 0 0", c, reached, busy, floor_tick);
      end
    end
    current_state = 32'd0;
    step();
  endtask

  // mode 0 stops with abort, mode 1 by leaving the move state
  task automatic test_abort(input int mode);
    pfloor = 5'd0; nfloor = 5'd10; current_state = 32'd4;
    step();
    repeat (8) step();
    if (mode == 0) abort = 1'b1;
    else current_state = 32'd3;
    step();
    tests++;
    if (busy !== 1'b0 || live_floor !== 5'd2 || reached !== 1'b0 || floor_tick !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_m%0d busy=%b live=%0d reached=%b tick=%b want 0 2 0 0",
               mode, busy, live_floor, reached, floor_tick);
    end
    abort = 1'b0; current_state = 32'd0;
    step();
    tests++;
    if (busy !== 1'b0 || reached !== 1'b0 || live_floor !== 5'd2) begin
      fails++;
      $display("[TB] FAIL abort_m%0d_idle busy=%b reached=%b live=%0d want 0 0 2", mode, busy, reached, live_floor);
    end
  endtask

  task automatic test_fast_travel();
    pfloor = 5'd0; nfloor = 5'd3; current_state = 32'd4;
    step();
    tests++;
    if (busy2 !== 1'b1 || live_floor2 !== 5'd0 || floor_tick2 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL fast_start busy=%b live=%0d tick=%b want 1 0 0", busy2, live_floor2, floor_tick2);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      tests++;
      if (floor_tick2 !== 1'b1 || live_floor2 !== 5'(c) || reached2 !== (c == 3) || busy2 !== (c < 3)) begin
        fails++;
        $display("[TB] FAIL fast_cycle%0d tick=%b live=%0d reached=%b busy=%b want 1 %0d %b %b",
                 c, floor_tick2, live_floor2, reached2, busy2, c, (c == 3), (c < 3));
      end
    end
    step();
    tests++;
    if (floor_tick2 !== 1'b0 || reached2 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL fast_after tick=%b reached=%b want 0 0", floor_tick2, reached2);
    end
    current_state = 32'd0;
    step();
  endtask

  task automatic test_reset_midrun();
    pfloor = 5'd0; nfloor = 5'd10; current_state = 32'd4;
    step();
    repeat (4) step();
    tests++;
    if (busy !== 1'b1 || live_floor !== 5'd1 || busy2 !== 1'b1 || live_floor2 !== 5'd4) begin
      fails++;
      $display("[TB] FAIL midrun_pre busy=%b live=%0d busy2=%b live2=%0d want 1 1 1 4",
               busy, live_floor, busy2, live_floor2);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, live_floor, floor_tick, reached, req_err,
         busy2, live_floor2, floor_tick2, reached2, req_err2} !== 18'b0) begin
      fails++;
      $display("[TB] FAIL midrun_reset got %b want 0",
               {busy, live_floor, floor_tick, reached, req_err,
                busy2, live_floor2, floor_tick2, reached2, req_err2});
    end
    current_state = 32'd0;
    step();
    tests++;
    if (reached !== 1'b0 || reached2 !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrun_hold reached=%b reached2=%b busy=%b want 0 0 0", reached, reached2, busy);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_up_travel();
    test_down_travel();
    test_req_err();
    test_same_floor();
    test_abort(0);
    test_abort(1);
    test_fast_travel();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lift_travel_timer.md
Name: lift_travel_timer

Overview:
Parametrised successor to the single-speed lift travel timer. It counts travel time floor by floor while the lift controller is in a move state. It tracks the live floor position and emits a per-floor tick and a one-cycle reached pulse. It also flags illegal requests and supports abort. It sits between the lift controller FSM (which supplies current_state, pfloor and nfloor) and the floor display / door logic.

Parameters:
STATE_W, 32, width of the current_state encoding
FLOOR_W, 5, width of the floor index ports
NUM_FLOORS, 16, number of valid floors; legal floors are 0..NUM_FLOORS-1 (must be <= 2^FLOOR_W)
CYC_PER_FLOOR, 4, clock cycles to travel one floor (must be >= 1)
CNT_W, 16, width of the per-floor cycle counter (must hold CYC_PER_FLOOR-1)
ST_MOVE_UP, 4, current_state encoding for move up
ST_MOVE_DOWN, 5, current_state encoding for move down

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
current_state  in  STATE_W  lift controller state
pfloor  in  FLOOR_W  present floor, sampled only at travel start
nfloor  in  FLOOR_W  next (target) floor, sampled only at travel start
abort  in  1  synchronous abort of the current travel
busy  out  1  high while travel is being timed
live_floor  out  FLOOR_W  floor the car is currently at or passing
floor_tick  out  1  one-cycle pulse each time a floor boundary is crossed
reached  out  1  one-cycle pulse when the target floor is reached
req_err  out  1  one-cycle pulse on an illegal travel request

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE; busy, floor_tick, reached, req_err=0; live_floor=0; cycle counter=0.
- All outputs are registered. floor_tick, reached and req_err are high for exactly one cycle per event.
- "move" means current_state==ST_MOVE_UP or current_state==ST_MOVE_DOWN.
- FSM states: IDLE, RUN, DONE.
- IDLE, move not active: remain in IDLE; live_floor holds.
- IDLE, move active, sampled at edge E0:
  - If pfloor>=NUM_FLOORS, nfloor>=NUM_FLOORS, ST_MOVE_UP with nfloor<pfloor, or ST_MOVE_DOWN with nfloor>pfloor: req_err=1 after E0, remain in IDLE.
  - If nfloor==pfloor: reached=1 after E0, live_floor=pfloor, busy stays 0, go to DONE.
  - Otherwise: latch target=nfloor and direction, live_floor=pfloor, counter=0, busy=1, go to RUN.
- RUN, each cycle:
  - If abort=1 or move is no longer active: go to IDLE, busy=0. No reached pulse. live_floor holds its last value. Abort has priority over a coincident floor crossing.
  - Else if counter==CYC_PER_FLOOR-1: counter=0; live_floor +/-1 per direction; floor_tick=1. If the new live_floor==target, reached=1, busy=0, go to DONE.
  - Else counter+1.
- Latency: for N floors, floor_tick k is asserted after edge E0+k*CYC_PER_FLOOR (k=1..N). reached coincides with tick N, after edge E0+N*CYC_PER_FLOOR. With CYC_PER_FLOOR=1, ticks occur every cycle.
- pfloor and nfloor changes during RUN are ignored, because values are latched at start.
- DONE: remain in DONE while move is active, so a new travel cannot retrigger in the same move state. When move is no longer active, go to IDLE. A new travel requires move to re-assert from IDLE.
- abort has no effect in IDLE or DONE.
- live_floor never wraps: it stops at target, which is always < NUM_FLOORS.
- Reset mid-RUN: all state clears immediately. No reached pulse is issued.

Test Plan:
- Defaults; pfloor=2, nfloor=5, current_state=4 held -> floor_tick after E0+4, +8, +12; live_floor 3,4,5; reached=1 for one cycle after E0+12; busy 1->0.
- pfloor=9, nfloor=1, current_state=5 -> 8 ticks spaced 4 cycles apart; live_floor 8..1; reached after E0+32; no retrigger while state stays 5.
- current_state=4, pfloor=6, nfloor=3 -> req_err pulse after E0, busy=0. Repeat with nfloor=20 (>=NUM_FLOORS) -> req_err pulse, busy=0.
- pfloor=nfloor=7, state=4 -> reached pulse after E0, zero floor_ticks, busy never 1.
- Travel 0->10 with abort=1 at E0+9 -> busy=0 next cycle, live_floor=2, no reached. Repeat with current_state dropped to 3 instead of abort -> same result.
- CYC_PER_FLOOR=1: 0->3 -> ticks on 3 consecutive cycles, reached with the third. Assert rst_n=0 mid-run -> all outputs 0 asynchronously.
